// File: rtl/jg_bus_decode.sv
// ---------------------------------------------------------------------------
// jg_bus_decode
//
// Z80 (T80) bus decoder for Kiwako-class cores. Decodes memory regions from
// base/mask parameters with priority (index 0 wins), inserts per-region wait
// states through WAIT_n, generates one-clock I/O write strobes, keeps the
// flip latch and records the first unmapped access for debug.
//
// Ports
//   clk         in   system clock, all state on rising edge
//   reset_n     in   asynchronous active-low reset
//   cpu_ab      in   CPU address
//   cpu_do      in   CPU write data
//   cpu_mreq    in   memory request (active high)
//   cpu_iorq    in   I/O request (active high)
//   cpu_m1      in   M1 (active high)
//   cpu_rd      in   read (active high)
//   cpu_wr      in   write (active high)
//   cpu_wait_n  out  CPU wait, low stretches the cycle
//   mem_cs      out  one-hot region select (combinational)
//   io_rd_cs    out  port read select (combinational level)
//   io_wr_stb   out  port write strobe (registered, one clock wide)
//   flip        out  flip latch
//   unmap_clr   in   clears the unmapped capture
//   unmap_flag  out  sticky unmapped-access flag
//   unmap_addr  out  address of the first unmapped access
//   unmap_io    out  captured access was I/O
//   dbg_state   out  wait FSM state (0 IDLE, 1 WAIT, 2 HOLD)
//
// Handshake: an access is a level on mreq/iorq qualified by rd/wr. An access
// "starts" in the first clock its qualified level is seen (level high, the
// registered copy low); every per-access action keys off that start, so a
// held access is acted on once and the next one needs the level to drop.
// ---------------------------------------------------------------------------
module jg_bus_decode #(
    parameter int                   NREG     = 5,
    parameter logic [NREG*16-1:0]   REG_BASE = {16'hE400, 16'hE000, 16'hA000, 16'h8000, 16'h0000},
    parameter logic [NREG*16-1:0]   REG_MASK = {16'hFC00, 16'hFC00, 16'hF800, 16'hF800, 16'h8000},
    parameter int                   WS_W     = 3,
    parameter logic [NREG*WS_W-1:0] REG_WS   = '0,
    parameter int                   NPORT    = 4,
    parameter int                   FLIP_BIT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [15:0]      cpu_ab,
    input  logic [7:0]       cpu_do,
    input  logic             cpu_mreq,
    input  logic             cpu_iorq,
    input  logic             cpu_m1,
    input  logic             cpu_rd,
    input  logic             cpu_wr,
    output logic             cpu_wait_n,
    output logic [NREG-1:0]  mem_cs,
    output logic [NPORT-1:0] io_rd_cs,
    output logic [NPORT-1:0] io_wr_stb,
    output logic             flip,
    input  logic             unmap_clr,
    output logic             unmap_flag,
    output logic [15:0]      unmap_addr,
    output logic             unmap_io,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [8:0] NPORT_L = 9'(NPORT);

    // Access qualification
    logic w_mem_act;
    logic w_io_act;
    logic w_mem_start;
    logic w_io_start;

    // Region decode
    logic [NREG-1:0] w_hit;
    logic [NREG-1:0] w_sel;
    logic [WS_W-1:0] w_sel_ws;
    logic            w_found;

    // Port decode
    logic [NPORT-1:0] w_port_dec;
    logic             w_port_ok;

    // Unmapped detection
    logic w_mem_unmap;
    logic w_io_unmap;
    logic w_unmap_start;

    // State
    logic             r_mem_act_q;
    logic             r_io_act_q;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [WS_W-1:0]  r_cnt;
    logic [WS_W-1:0]  w_cnt_nxt;
    logic [NPORT-1:0] r_io_wr_stb;
    logic             r_flip;
    logic             r_unmap_flag;
    logic [15:0]      r_unmap_addr;
    logic             r_unmap_io;

    // iorq wins over mreq; iorq together with m1 is interrupt acknowledge
    assign w_mem_act   = cpu_mreq & (cpu_rd | cpu_wr) & ~cpu_iorq;
    assign w_io_act    = cpu_iorq & ~cpu_m1 & (cpu_rd | cpu_wr);
    assign w_mem_start = w_mem_act & ~r_mem_act_q;
    assign w_io_start  = w_io_act & ~r_io_act_q;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NREG; i++) begin
            w_hit[i] = ((cpu_ab & REG_MASK[16*i +: 16]) == REG_BASE[16*i +: 16]);
        end
    end

    // Lowest index hit wins; its wait-state count travels with the select
    always_comb begin
        w_sel    = '0;
        w_sel_ws = '0;
        w_found  = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (w_hit[i] && !w_found) begin
                w_sel[i] = 1'b1;
                w_sel_ws = REG_WS[WS_W*i +: WS_W];
                w_found  = 1'b1;
            end
        end
    end

    assign mem_cs = w_mem_act ? w_sel : '0;

    always_comb begin
        w_port_dec = '0;
        for (int p = 0; p < NPORT; p++) begin
            w_port_dec[p] = (cpu_ab[7:0] == 8'(p));
        end
    end

    assign w_port_ok = ({1'b0, cpu_ab[7:0]} < NPORT_L);
    assign io_rd_cs  = (w_io_act & cpu_rd) ? w_port_dec : '0;

    assign w_mem_unmap   = w_mem_start & ~w_found;
    assign w_io_unmap    = w_io_start & ~w_port_ok;
    assign w_unmap_start = w_mem_unmap | w_io_unmap;

    // Wait FSM next state
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_mem_start) begin
                    if (w_sel_ws != '0) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = w_sel_ws;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_WAIT: begin
                if (!w_mem_act) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt <= WS_W'(1)) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - WS_W'(1);
                end
            end
            ST_HOLD: begin
                if (!w_mem_act) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Derived from state so an asynchronous reset releases WAIT at once
    assign cpu_wait_n = (r_state != ST_WAIT);
    assign dbg_state  = r_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_act_q <= 1'b0;
            r_io_act_q  <= 1'b0;
            r_io_wr_stb <= '0;
            r_flip      <= 1'b0;
        end else begin
            r_mem_act_q <= w_mem_act;
            r_io_act_q  <= w_io_act;
            r_io_wr_stb <= (w_io_start & cpu_wr) ? w_port_dec : '0;
            if (w_io_start && cpu_wr && w_port_dec[0]) begin
                r_flip <= cpu_do[FLIP_BIT];
            end
        end
    end

    // A new unmapped start beats a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_unmap_flag <= 1'b0;
            r_unmap_addr <= '0;
            r_unmap_io   <= 1'b0;
        end else if (w_unmap_start && (!r_unmap_flag || unmap_clr)) begin
            r_unmap_flag <= 1'b1;
            r_unmap_addr <= cpu_ab;
            r_unmap_io   <= w_io_unmap;
        end else if (unmap_clr) begin
            r_unmap_flag <= 1'b0;
            r_unmap_addr <= '0;
            r_unmap_io   <= 1'b0;
        end
    end

    assign io_wr_stb  = r_io_wr_stb;
    assign flip       = r_flip;
    assign unmap_flag = r_unmap_flag;
    assign unmap_addr = r_unmap_addr;
    assign unmap_io   = r_unmap_io;

endmodule

// File: tb/tb_jg_bus_decode.sv
// ---------------------------------------------------------------------------
// tb_jg_bus_decode
//
// Directed bench for jg_bus_decode with the default memory map and region 2
// configured for three wait states. Inputs change 1 ns after a rising edge;
// combinational outputs are checked after a further 1 ns, registered outputs
// 1 ns after the edge that updates them.
// ---------------------------------------------------------------------------
module tb_jg_bus_decode;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic        clk;
    logic        reset_n;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_mreq;
    logic        cpu_iorq;
    logic        cpu_m1;
    logic        cpu_rd;
    logic        cpu_wr;
    logic        cpu_wait_n;
    logic [4:0]  mem_cs;
    logic [3:0]  io_rd_cs;
    logic [3:0]  io_wr_stb;
    logic        flip;
    logic        unmap_clr;
    logic        unmap_flag;
    logic [15:0] unmap_addr;
    logic        unmap_io;
    logic [1:0]  dbg_state;

    int n_vec;
    int n_err;

    jg_bus_decode #(
        .REG_WS (15'h00C0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_ab     (cpu_ab),
        .cpu_do     (cpu_do),
        .cpu_mreq   (cpu_mreq),
        .cpu_iorq   (cpu_iorq),
        .cpu_m1     (cpu_m1),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_wait_n (cpu_wait_n),
        .mem_cs     (mem_cs),
        .io_rd_cs   (io_rd_cs),
        .io_wr_stb  (io_wr_stb),
        .flip       (flip),
        .unmap_clr  (unmap_clr),
        .unmap_flag (unmap_flag),
        .unmap_addr (unmap_addr),
        .unmap_io   (unmap_io),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        cpu_mreq = 1'b0;
        cpu_iorq = 1'b0;
        cpu_m1   = 1'b0;
        cpu_rd   = 1'b0;
        cpu_wr   = 1'b0;
        step();
    endtask

    task automatic mem_rd(input logic [15:0] addr);
        cpu_ab   = addr;
        cpu_mreq = 1'b1;
        cpu_rd   = 1'b1;
        #1;
    endtask

    task automatic io_wr(input logic [15:0] addr, input logic [7:0] data);
        cpu_ab   = addr;
        cpu_do   = data;
        cpu_iorq = 1'b1;
        cpu_wr   = 1'b1;
        #1;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        cpu_ab    = 16'h0000;
        cpu_do    = 8'h00;
        cpu_mreq  = 1'b0;
        cpu_iorq  = 1'b0;
        cpu_m1    = 1'b0;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        unmap_clr = 1'b0;

        // Reset held with a read at 1234
        mem_rd(16'h1234);
        step();
        step();
        chk("rst_mem_cs",  16'(mem_cs),     16'h0001);
        chk("rst_wait_n",  16'(cpu_wait_n), 16'h0001);
        chk("rst_flip",    16'(flip),       16'h0000);
        chk("rst_uflag",   16'(unmap_flag), 16'h0000);
        chk("rst_uaddr",   unmap_addr,      16'h0000);
        chk("rst_stb",     16'(io_wr_stb),  16'h0000);
        chk("rst_state",   16'(dbg_state),  16'(S_IDLE));

        cpu_mreq = 1'b0;
        cpu_rd   = 1'b0;
        reset_n  = 1'b1;
        step();
        mem_rd(16'h1234);
        chk("run_mem_cs",  16'(mem_cs),     16'h0001);
        step();
        chk("hold_state",  16'(dbg_state),  16'(S_HOLD));
        bus_idle();

        // Default map
        mem_rd(16'hE3FF);
        chk("e3ff_cs",     16'(mem_cs),     16'h0008);
        step();
        bus_idle();
        mem_rd(16'hE400);
        chk("e400_cs",     16'(mem_cs),     16'h0010);
        step();
        bus_idle();
        mem_rd(16'hC000);
        chk("c000_cs",     16'(mem_cs),     16'h0000);
        step();
        chk("c000_flag",   16'(unmap_flag), 16'h0001);
        chk("c000_addr",   unmap_addr,      16'hC000);
        chk("c000_io",     16'(unmap_io),   16'h0000);
        bus_idle();
        mem_rd(16'hD000);
        step();
        chk("d000_frozen", unmap_addr,      16'hC000);
        chk("d000_flag",   16'(unmap_flag), 16'h0001);
        bus_idle();
        unmap_clr = 1'b1;
        step();
        unmap_clr = 1'b0;
        chk("clr1_flag",   16'(unmap_flag), 16'h0000);

        // Region 2 with three wait states, held for 8 clocks
        mem_rd(16'hA010);
        chk("a010_cs",     16'(mem_cs),     16'h0004);
        chk("ws_c0",       16'(cpu_wait_n), 16'h0001);
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("ws_c%0d", k), 16'(cpu_wait_n), (k <= 3) ? 16'h0000 : 16'h0001);
        end
        chk("ws_end_state", 16'(dbg_state), 16'(S_HOLD));
        bus_idle();
        chk("ws_idle",     16'(dbg_state),  16'(S_IDLE));

        // Abort after one wait clock
        mem_rd(16'hA010);
        step();
        chk("ab_wait_n",   16'(cpu_wait_n), 16'h0000);
        chk("ab_state_w",  16'(dbg_state),  16'(S_WAIT));
        cpu_mreq = 1'b0;
        cpu_rd   = 1'b0;
        step();
        chk("ab_release",  16'(cpu_wait_n), 16'h0001);
        chk("ab_idle",     16'(dbg_state),  16'(S_IDLE));
        bus_idle();

        // Port 0 write, flip bit set, held 4 clocks
        io_wr(16'h0000, 8'h02);
        chk("p0_stb_c0",   16'(io_wr_stb),  16'h0000);
        step();
        chk("p0_stb_c1",   16'(io_wr_stb),  16'h0001);
        chk("p0_flip1",    16'(flip),       16'h0001);
        step();
        chk("p0_stb_c2",   16'(io_wr_stb),  16'h0000);
        step();
        chk("p0_stb_c3",   16'(io_wr_stb),  16'h0000);
        bus_idle();
        io_wr(16'h0000, 8'h00);
        step();
        chk("p0b_stb",     16'(io_wr_stb),  16'h0001);
        chk("p0_flip0",    16'(flip),       16'h0000);
        bus_idle();

        // Port 2 read with mreq also asserted: iorq wins
        cpu_ab   = 16'h0002;
        cpu_iorq = 1'b1;
        cpu_mreq = 1'b1;
        cpu_rd   = 1'b1;
        #1;
        chk("p2_rd_cs",    16'(io_rd_cs),   16'h0004);
        chk("p2_mem_cs",   16'(mem_cs),     16'h0000);
        step();
        chk("p2_stb",      16'(io_wr_stb),  16'h0000);
        bus_idle();

        // Interrupt acknowledge at port 0
        cpu_ab   = 16'h0000;
        cpu_iorq = 1'b1;
        cpu_m1   = 1'b1;
        cpu_rd   = 1'b1;
        cpu_wr   = 1'b1;
        #1;
        chk("inta_rd_cs",  16'(io_rd_cs),   16'h0000);
        step();
        chk("inta_stb",    16'(io_wr_stb),  16'h0000);
        chk("inta_unmap",  16'(unmap_flag), 16'h0000);
        bus_idle();

        // Unmapped port write
        io_wr(16'h3410, 8'h55);
        step();
        chk("p10_flag",    16'(unmap_flag), 16'h0001);
        chk("p10_io",      16'(unmap_io),   16'h0001);
        chk("p10_addr",    unmap_addr,      16'h3410);
        chk("p10_stb",     16'(io_wr_stb),  16'h0000);
        bus_idle();

        // Clear coinciding with a new unmapped start: capture wins
        unmap_clr = 1'b1;
        mem_rd(16'hC100);
        step();
        unmap_clr = 1'b0;
        chk("cc_flag",     16'(unmap_flag), 16'h0001);
        chk("cc_addr",     unmap_addr,      16'hC100);
        chk("cc_io",       16'(unmap_io),   16'h0000);
        bus_idle();
        unmap_clr = 1'b1;
        step();
        unmap_clr = 1'b0;
        chk("clr2_flag",   16'(unmap_flag), 16'h0000);
        chk("clr2_addr",   unmap_addr,      16'h0000);
        chk("clr2_io",     16'(unmap_io),   16'h0000);

        // Reset mid-access releases WAIT at once
        mem_rd(16'hA010);
        step();
        chk("mr_wait_n",   16'(cpu_wait_n), 16'h0000);
        reset_n = 1'b0;
        #1;
        chk("mr_release",  16'(cpu_wait_n), 16'h0001);
        chk("mr_state",    16'(dbg_state),  16'(S_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
